dbg_tx_arbiter: RTL and testbench
=================================

// Module: dbg_tx_arbiter
// PURPOSE
//  Shares one byte-wide UART transmitter among NREQ debug-frame requesters (writeback, ALU, fetch, PC/HI/LO taps).
//  Round-robin grant; the winner is locked until its frame ends. 32-bit words are serialised MSB-first behind a header byte.
//  Sits between the pipeline debug taps and the UART TX byte engine, on the qclk domain.
// PARAMETERS
//  NREQ       4   number of requesters (1..8)
//  MAX_WORDS  8   max words per frame; forced end beyond this
// PORTS
//  clk          in   1          clock
//  resetn       in   1          async reset, active-high (asserted = 1'b1)
//  en_i         in   1          arbitration enable; a new frame starts only while 1
//  req_i        in   NREQ       per-requester frame request (level)
//  word_i       in   32*NREQ    per-requester current word; slice k = [32k+31:32k]
//  last_i       in   NREQ       current word of requester k is its last
//  word_ack_o   out  NREQ       1-cycle pulse: word of granted requester latched
//  gnt_o        out  NREQ       one-hot grant, held for the whole frame
//  tx_data_o    out  8          byte to UART
//  tx_start_o   out  1          1-cycle pulse: start sending tx_data_o
//  tx_busy_i    in   1          UART busy
//  tx_done_i    in   1          1-cycle pulse: byte finished
//  ovf_o        out  1          sticky: frame cut at MAX_WORDS
//  abort_o      out  1          sticky: req dropped mid-frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer=0, byte counter=0, shift reg=0.
//  FSM states: IDLE, HDR, LOAD, BYTE, WAIT, TRAIL.
//  IDLE: if en_i & |req_i -> grant first requester at/after RR pointer (wrap NREQ-1->0); gnt_o set next cycle; ->HDR.
//  HDR: tx_data_o={4'hA,1'b0,id[2:0]}; tx_start_o when !tx_busy_i; ->WAIT (return target LOAD).
//  LOAD: latch word_i[gnt], word_ack_o pulse same cycle, capture last_i; ->BYTE.
//  BYTE: emit shift[31:24], tx_start_o when !tx_busy_i; shift left 8; ->WAIT.
//  WAIT: hold until tx_done_i; then: bytes left -> BYTE; word done and not last -> LOAD;
//        word done and last -> TRAIL (if CHECKSUM) else release.
//  Release: gnt_o=0, RR pointer = granted id + 1 (mod NREQ), ->IDLE; min 1 idle cycle between frames.
//  tx_start_o never asserted while tx_busy_i=1 or while a byte is outstanding (one byte in flight max).
//  Word count wraps nothing: on MAX_WORDS-th word with last=0, treat as last and set ovf_o.
//  req_i[gnt] low at LOAD entry: no ack, set abort_o, release (no trailer). Drop during BYTE/WAIT: current word completes.
//  en_i low mid-frame: frame completes; only new grants are blocked.
//  tx_done_i outside WAIT: ignored. Simultaneous release and new requests: new grant no earlier than next IDLE cycle.
//  Latency: req to first tx_start_o = 3 cycles with UART idle.
//  Reset mid-frame: immediate return to reset state; a partial byte on the line is the UART's concern.
//  ovf_o/abort_o clear only on reset.
// CONFIGURATION
//  DBG_TX_ARB_CHECKSUM_EN defined: TRAIL state sends XOR of header and all data bytes after the last word, then releases.
//  Undefined: no TRAIL state, no checksum register; frame ends after the last data byte.
// STRUCTURE
//  Shared package/defines: FSM state encodings, header nibble 4'hA, requester IDs (WB=0, ALU=1, IF=2, PCHL=3).
//  One sub-module: rr_pick (combinational round-robin one-hot picker, NREQ param) reused by other arbiters.
// TESTING
//  Single req0, word 0x12345678, last=1, UART 4-cycle done -> bytes A0,12,34,56,78; one word_ack; gnt released.
//  req0+req2 together, ptr=0 -> frame 0 then frame 2; then req0 again with ptr=1 -> req2 wins if also requesting.
//  3-word frame from req1 -> header A1 + 12 bytes, 3 acks, each word_ack before its first byte.
//  MAX_WORDS=2, last never set -> 2 words sent, ovf_o=1, next requester served.
//  req dropped before 2nd LOAD -> first word complete, abort_o=1, no further bytes.
//  CHECKSUM_EN: word 0x01020304 from req0 -> trailer A0^01^02^03^04 = A4; without macro no trailer.

Source files
------------

// File: rtl/dbg_tx_arbiter_pkg.sv
// Shared definitions for the debug-frame UART arbiter: FSM encodings, header nibble, requester IDs.
// DBG_TX_ARB_CHECKSUM_EN adds the TRAIL state (XOR checksum byte after the last data byte).
package dbg_tx_arbiter_pkg;

  localparam int ID_W = 3;
  localparam logic [3:0] HDR_NIB = 4'hA;

  localparam logic [ID_W-1:0] ID_WB   = 3'd0;
  localparam logic [ID_W-1:0] ID_ALU  = 3'd1;
  localparam logic [ID_W-1:0] ID_IF   = 3'd2;
  localparam logic [ID_W-1:0] ID_PCHL = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_BYTE  = 3'd3,
`ifdef DBG_TX_ARB_CHECKSUM_EN
    ST_TRAIL = 3'd5,
`endif
    ST_WAIT  = 3'd4
  } state_e;

  // Which kind of byte is in flight while the FSM sits in WAIT.
  typedef enum logic [1:0] {
    PH_HDR   = 2'd0,
    PH_DATA  = 2'd1,
    PH_TRAIL = 2'd2
  } phase_e;

  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    return {HDR_NIB, 1'b0, id};
  endfunction

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int n);
    logic [ID_W-1:0] nxt;
    if (int'(id) >= n - 1) nxt = '0;
    else nxt = id + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/dbg_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first request at/after ptr_i, wrapping.
module dbg_tx_arbiter_rr_pick
  import dbg_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] id_o,
  output logic            valid_o
);

  int   idx_s;
  logic hit_s;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx_s   = 0;
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = (int'(ptr_i) + i >= NREQ) ? int'(ptr_i) + i - NREQ : int'(ptr_i) + i;
      for (int j = 0; j < NREQ; j++) begin
        hit_s    = !valid_o && (idx_s == j) && req_i[j];
        gnt_o[j] = gnt_o[j] | hit_s;
        id_o     = hit_s ? ID_W'(j) : id_o;
        valid_o  = valid_o | hit_s;
      end
    end
  end

endmodule

// File: rtl/dbg_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NREQ debug-frame requesters.
// Optional DBG_TX_ARB_CHECKSUM_EN appends an XOR checksum byte to each completed frame.
module dbg_tx_arbiter
  import dbg_tx_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_WORDS = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               en_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [32*NREQ-1:0] word_i,
  input  logic [NREQ-1:0]    last_i,
  output logic [NREQ-1:0]    word_ack_o,
  output logic [NREQ-1:0]    gnt_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_busy_i,
  input  logic               tx_done_i,
  output logic               ovf_o,
  output logic               abort_o
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              last_q, last_d;
  logic [31:0]       shift_q, shift_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ovf_q, ovf_d, abort_q, abort_d;
`ifdef DBG_TX_ARB_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [NREQ-1:0]   pick_gnt_s;
  logic [ID_W-1:0]   pick_id_s;
  logic              pick_valid_s;
  logic [31:0]       word_sel_s;
  logic              req_sel_s, last_sel_s, rel_s;

  dbg_tx_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt_s),
    .id_o    (pick_id_s),
    .valid_o (pick_valid_s)
  );

  // Mux out the granted requester's word, request and last flag.
  always_comb begin
    word_sel_s = '0;
    req_sel_s  = 1'b0;
    last_sel_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      word_sel_s = (id_q == ID_W'(k)) ? word_i[32*k +: 32] : word_sel_s;
      req_sel_s  = (id_q == ID_W'(k)) ? req_i[k]  : req_sel_s;
      last_sel_s = (id_q == ID_W'(k)) ? last_i[k] : last_sel_s;
    end
  end

  // Frame sequencing; at most one byte outstanding at the UART.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    last_d     = last_q;
    shift_d    = shift_q;
    gnt_d      = gnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    ovf_d      = ovf_q;
    abort_d    = abort_q;
    rel_s      = 1'b0;
`ifdef DBG_TX_ARB_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en_i && pick_valid_s) begin
          state_d = ST_HDR;
          gnt_d   = pick_gnt_s;
          id_d    = pick_id_s;
          phase_d = PH_HDR;
          wcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!tx_busy_i) begin
          tx_data_d  = hdr_byte(id_q);
          tx_start_d = 1'b1;
          state_d    = ST_WAIT;
`ifdef DBG_TX_ARB_CHECKSUM_EN
          csum_d     = hdr_byte(id_q);
`endif
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (req_sel_s) begin
          shift_d = word_sel_s;
          ack_d   = gnt_q;
          bcnt_d  = 3'd4;
          wcnt_d  = wcnt_q + WC_W'(1);
          phase_d = PH_DATA;
          state_d = ST_BYTE;
          // The MAX_WORDS-th word always ends the frame; flag it if the requester disagreed.
          if (last_sel_s) begin
            last_d = 1'b1;
          end else if (wcnt_q == WC_W'(MAX_WORDS - 1)) begin
            last_d = 1'b1;
            ovf_d  = 1'b1;
          end else begin
            last_d = 1'b0;
          end
        end else begin
          abort_d = 1'b1;
          rel_s   = 1'b1;
        end
      end
      ST_BYTE: begin
        if (!tx_busy_i) begin
          tx_data_d  = shift_q[31:24];
          tx_start_d = 1'b1;
          shift_d    = {shift_q[23:0], 8'h00};
          bcnt_d     = bcnt_q - 3'd1;
          state_d    = ST_WAIT;
`ifdef DBG_TX_ARB_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q[31:24];
`endif
        end else begin
          state_d = ST_BYTE;
        end
      end
      ST_WAIT: begin
        if (!tx_done_i) begin
          state_d = ST_WAIT;
        end else if (phase_q == PH_HDR) begin
          state_d = ST_LOAD;
        end else if (phase_q == PH_TRAIL) begin
          rel_s = 1'b1;
        end else if (bcnt_q != 3'd0) begin
          state_d = ST_BYTE;
        end else if (!last_q) begin
          state_d = ST_LOAD;
        end else begin
`ifdef DBG_TX_ARB_CHECKSUM_EN
          state_d = ST_TRAIL;
`else
          rel_s = 1'b1;
`endif
        end
      end
`ifdef DBG_TX_ARB_CHECKSUM_EN
      ST_TRAIL: begin
        if (!tx_busy_i) begin
          tx_data_d  = csum_q;
          tx_start_d = 1'b1;
          phase_d    = PH_TRAIL;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_TRAIL;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    // Release always passes through IDLE, so frames are separated by at least one idle cycle.
    if (rel_s) begin
      gnt_d   = '0;
      ptr_d   = rr_next(id_q, NREQ);
      state_d = ST_IDLE;
    end else begin
      ptr_d = ptr_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_HDR;
      id_q       <= '0;
      ptr_q      <= '0;
      bcnt_q     <= 3'd0;
      wcnt_q     <= '0;
      last_q     <= 1'b0;
      shift_q    <= 32'h0;
      gnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      ovf_q      <= 1'b0;
      abort_q    <= 1'b0;
`ifdef DBG_TX_ARB_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      gnt_q      <= gnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      abort_q    <= abort_d;
`ifdef DBG_TX_ARB_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign word_ack_o = ack_q;
  assign gnt_o      = gnt_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign ovf_o      = ovf_q;
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_dbg_tx_arbiter.sv
// Scoreboard bench for dbg_tx_arbiter: expected UART bytes and word acks are queued per frame
// and matched in order against DUT events; a 4-cycle UART model answers each tx_start.
module tb_dbg_tx_arbiter;

  localparam int NREQ = 4;
  localparam int MAXW = 4;

  logic               clk;
  logic               resetn;
  logic               en_i;
  logic [NREQ-1:0]    req_i;
  logic [32*NREQ-1:0] word_i;
  logic [NREQ-1:0]    last_i;
  logic [NREQ-1:0]    word_ack_o;
  logic [NREQ-1:0]    gnt_o;
  logic [7:0]         tx_data_o;
  logic               tx_start_o;
  logic               tx_busy_i;
  logic               tx_done_i;
  logic               ovf_o;
  logic               abort_o;

  dbg_tx_arbiter #(.NREQ(NREQ), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en_i       (en_i),
    .req_i      (req_i),
    .word_i     (word_i),
    .last_i     (last_i),
    .word_ack_o (word_ack_o),
    .gnt_o      (gnt_o),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .tx_busy_i  (tx_busy_i),
    .tx_done_i  (tx_done_i),
    .ovf_o      (ovf_o),
    .abort_o    (abort_o)
  );

  int checks   = 0;
  int failures = 0;

  // token = {grant one-hot, is_ack, byte or ack one-hot}
  logic [16:0] exp_q[$];

  logic [31:0] words[NREQ][8];
  int wlen[NREQ]     = '{default: 0};
  int drop_at[NREQ]  = '{default: -1};
  bit nolast[NREQ]   = '{default: 1'b0};
  int arm_cnt[NREQ]  = '{default: 0};
  int seen_arm[NREQ] = '{default: 0};
  int widx[NREQ]     = '{default: 0};
  int ucnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_tok(input string tag, input logic [16:0] tok);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(tok), 32'h1FFFF);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(tok), 32'(e));
    end
  endtask

  task automatic push_frame(input int k, input int n, input bit trail);
    logic [7:0] g, hdr, cs, b;
    g   = 8'b1 << k;
    hdr = {4'hA, 1'b0, 3'(k)};
    cs  = hdr;
    exp_q.push_back({g, 1'b0, hdr});
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({g, 1'b1, g});
      for (int i = 0; i < 4; i++) begin
        b  = words[k][w][31-8*i -: 8];
        cs = cs ^ b;
        exp_q.push_back({g, 1'b0, b});
      end
    end
`ifdef DBG_TX_ARB_CHECKSUM_EN
    if (trail) exp_q.push_back({g, 1'b0, cs});
`else
    if (trail) cs = 8'h00;
`endif
  endtask

  task automatic arm(input int k, input int len, input bit nl, input int drop);
    wlen[k]    = len;
    nolast[k]  = nl;
    drop_at[k] = drop;
    arm_cnt[k] = arm_cnt[k] + 1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gnt_o != '0 || tx_busy_i) && n < 800) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_drain"}, 32'(n < 800), 32'd1);
    check({tag, "_gnt_released"}, 32'(gnt_o), 32'd0);
  endtask

  // Requester model: presents its word list, advancing on each word_ack.
  initial begin
    req_i  = '0;
    word_i = '0;
    last_i = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (arm_cnt[k] != seen_arm[k]) begin
          seen_arm[k] = arm_cnt[k];
          widx[k] = 0;
        end else if (word_ack_o[k]) begin
          widx[k] = widx[k] + 1;
        end
        req_i[k] = (widx[k] < wlen[k]) && (drop_at[k] < 0 || widx[k] < drop_at[k]);
        word_i[32*k +: 32] = (widx[k] < wlen[k]) ? words[k][widx[k] % 8] : 32'h0;
        last_i[k] = (widx[k] == wlen[k] - 1) && !nolast[k];
      end
    end
  end

  // UART model and event monitor.
  initial begin
    tx_busy_i = 1'b0;
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        ucnt = 0;
        tx_busy_i = 1'b0;
        tx_done_i = 1'b0;
      end else begin
        if (word_ack_o != '0) expect_tok("ack", {8'(gnt_o), 1'b1, 8'(word_ack_o)});
        if (tx_start_o) begin
          check("start_while_busy", 32'(ucnt), 32'd0);
          expect_tok("byte", {8'(gnt_o), 1'b0, tx_data_o});
        end
        tx_done_i = 1'b0;
        if (ucnt > 0) begin
          ucnt = ucnt - 1;
          if (ucnt == 0) begin
            tx_busy_i = 1'b0;
            tx_done_i = 1'b1;
          end
        end
        if (tx_start_o) begin
          tx_busy_i = 1'b1;
          ucnt = 4;
        end
      end
    end
  end

  initial begin
    int n;
    resetn = 1'b1;
    en_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_start", 32'(tx_start_o), 32'd0);
    check("rst_ack", 32'(word_ack_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_abort", 32'(abort_o), 32'd0);
    resetn = 1'b0;
    en_i   = 1'b1;
    @(negedge clk);

    // Single word from req0, plus first-start latency.
    words[0][0] = 32'h12345678;
    push_frame(0, 1, 1'b1);
    arm(0, 1, 1'b0, -1);
    @(posedge clk); #2;
    n = 0;
    while (!tx_start_o && n < 3) begin
      @(posedge clk); #2;
      n++;
    end
    check("first_start_latency", 32'(tx_start_o), 32'd1);
    wait_drain("single");
    check("single_ovf", 32'(ovf_o), 32'd0);
    check("single_abort", 32'(abort_o), 32'd0);

    // req0 and req2 together with pointer at 1: req2 first, then req0.
    words[0][0] = 32'hCAFEF00D;
    words[2][0] = 32'h0BADBEEF;
    push_frame(2, 1, 1'b1);
    push_frame(0, 1, 1'b1);
    arm(0, 1, 1'b0, -1);
    arm(2, 1, 1'b0, -1);
    wait_drain("rr_pair");

    // Three-word frame from req1; en_i dropped mid-frame must not cut it.
    words[1][0] = 32'h11223344;
    words[1][1] = 32'h55667788;
    words[1][2] = 32'h99AABBCC;
    push_frame(1, 3, 1'b1);
    arm(1, 3, 1'b0, -1);
    repeat (12) @(negedge clk);
    en_i = 1'b0;
    wait_drain("three_words");

    // en_i low blocks a new grant.
    words[2][0] = 32'hDEADBEEF;
    arm(2, 1, 1'b0, -1);
    repeat (10) @(negedge clk);
    check("en_low_no_grant", 32'(gnt_o), 32'd0);
    push_frame(2, 1, 1'b1);
    en_i = 1'b1;
    wait_drain("en_resume");

    // Pointer at 3: req3 never flags last, cut at MAXW words; req0 served afterwards.
    check("pre_ovf", 32'(ovf_o), 32'd0);
    for (int w = 0; w < 4; w++) words[3][w] = 32'hA0B0C0D0 + 32'(w);
    words[0][0] = 32'h0F1E2D3C;
    push_frame(3, 4, 1'b1);
    push_frame(0, 1, 1'b1);
    arm(3, 4, 1'b1, -1);
    arm(0, 1, 1'b0, -1);
    wait_drain("overflow");
    check("ovf_set", 32'(ovf_o), 32'd1);
    check("ovf_no_abort", 32'(abort_o), 32'd0);

    // req1 drops its request after the first word: word completes, no more bytes.
    words[1][0] = 32'h5A5AA5A5;
    words[1][1] = 32'hFFFFFFFF;
    push_frame(1, 1, 1'b0);
    arm(1, 2, 1'b0, 1);
    wait_drain("drop");
    check("abort_set", 32'(abort_o), 32'd1);
    check("abort_keeps_ovf", 32'(ovf_o), 32'd1);

    // Checksum reference vector (trailer only when the checksum build is used).
    words[0][0] = 32'h01020304;
    push_frame(0, 1, 1'b1);
    arm(0, 1, 1'b0, -1);
    wait_drain("csum_vec");

    // Reset mid-frame clears everything, including sticky flags and the pointer.
    words[2][0] = 32'h13579BDF;
    words[2][1] = 32'h2468ACE0;
    push_frame(2, 2, 1'b1);
    arm(2, 2, 1'b0, -1);
    repeat (9) @(negedge clk);
    #2;
    resetn = 1'b1;
    exp_q.delete();
    wlen[2] = 0;
    @(negedge clk);
    check("midrst_gnt", 32'(gnt_o), 32'd0);
    check("midrst_start", 32'(tx_start_o), 32'd0);
    check("midrst_ovf", 32'(ovf_o), 32'd0);
    check("midrst_abort", 32'(abort_o), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);

    // Pointer back at 0: req1 beats req3.
    words[1][0] = 32'h00FF00FF;
    words[3][0] = 32'h7E7E8181;
    push_frame(1, 1, 1'b1);
    push_frame(3, 1, 1'b1);
    arm(1, 1, 1'b0, -1);
    arm(3, 1, 1'b0, -1);
    wait_drain("post_reset_rr");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
